// File: rtl/jump_redirect_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jump_redirect_ctrl_pkg
// Description : Shared processor defines for the jump redirect path.
//               Holds the decoder jump_control encodings and the
//               jump_redirect_ctrl FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package jump_redirect_ctrl_pkg;

    // Decoder jump_control encodings; 2'b11 is unused and treated as a no-op.
    localparam logic [1:0] JMP_NOP  = 2'b00;
    localparam logic [1:0] JMP_JAL  = 2'b01;
    localparam logic [1:0] JMP_JALR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RF_READ   = 3'd1,
        ST_REDIRECT  = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_FLUSH     = 3'd4
    } jmp_state_e;

endpackage : jump_redirect_ctrl_pkg
`default_nettype wire

// File: rtl/jump_target_calc.sv
`default_nettype none
// ============================================================================
// Module      : jump_target_calc
// Description : Combinational jump target and link address arithmetic.
//               JAL : target = pc + sext(imm[20:0])
//               JALR: target = (operand + sext(imm[11:0])) & ~1
//               link = pc + 4. All sums wrap modulo 2^32.
// Ports       : pc, operand, imm, is_jalr (in); target, link (out)
// Revision    : 1.0 - initial release
// ============================================================================
module jump_target_calc (
    input  logic [31:0] pc,
    input  logic [31:0] operand,
    input  logic [20:0] imm,
    input  logic        is_jalr,
    output logic [31:0] target,
    output logic [31:0] link
);

    logic [31:0] w_imm_j;
    logic [31:0] w_imm_i;
    logic [31:0] w_jalr_sum;

    assign w_imm_j    = {{11{imm[20]}}, imm};
    assign w_imm_i    = {{20{imm[11]}}, imm[11:0]};
    assign w_jalr_sum = operand + w_imm_i;

    assign target = is_jalr ? {w_jalr_sum[31:1], 1'b0} : (pc + w_imm_j);
    assign link   = pc + 32'd4;

endmodule : jump_target_calc
`default_nettype wire

// File: rtl/jump_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : jump_redirect_ctrl
// Description : Accepts a decoded JAL/JALR, reads rs1 from the register file
//               when needed, issues a one-cycle PC redirect, writes the link
//               address back to rd, then holds flush for FLUSH_CYCLES cycles.
// Ports       : clk, reset (async, active-high)
//               jmp_valid/jmp_ready + jump_control, rd, rs1, imm, pc
//               rf_rd_req/rf_rd_addr/rf_rd_ack/rf_rd_data
//               wb_valid/wb_rd/wb_data/wb_ready
//               redirect_valid, redirect_pc, flush, busy
//               trap_misalign (only with JUMP_MISALIGN_TRAP_EN)
// Config      : JUMP_MISALIGN_TRAP_EN - when defined, a target with bit 1 set
//               raises trap_misalign instead of redirecting.
// Revision    : 1.0 - initial release
// ============================================================================
module jump_redirect_ctrl
    import jump_redirect_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        jmp_valid,
    output logic        jmp_ready,
    input  logic [1:0]  jump_control,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [20:0] imm,
    input  logic [31:0] pc,
    output logic        rf_rd_req,
    output logic [4:0]  rf_rd_addr,
    input  logic        rf_rd_ack,
    input  logic [31:0] rf_rd_data,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    input  logic        wb_ready,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        busy
`ifdef JUMP_MISALIGN_TRAP_EN
    ,
    output logic        trap_misalign
`endif
);

    localparam logic [2:0] c_flush_load = 3'(FLUSH_CYCLES - 1);

    jmp_state_e  r_state;
    logic [31:0] r_pc;
    logic [4:0]  r_rd;
    logic [4:0]  r_rs1;
    logic [20:0] r_imm;
    logic [1:0]  r_jc;
    logic [31:0] r_target;
    logic [2:0]  r_flush_cnt;

    logic [31:0] w_calc_pc;
    logic [20:0] w_calc_imm;
    logic        w_calc_jalr;
    logic [31:0] w_operand;
    logic [31:0] w_target;
    logic [31:0] w_link;
    logic        w_misalign;

    // In IDLE the calculator works on the live decoder fields so the target
    // is ready on the transfer edge; afterwards it works on latched fields.
    assign w_calc_pc   = (r_state == ST_IDLE) ? pc  : r_pc;
    assign w_calc_imm  = (r_state == ST_IDLE) ? imm : r_imm;
    assign w_calc_jalr = (r_state == ST_IDLE) ? (jump_control == JMP_JALR)
                                              : (r_jc == JMP_JALR);
    // rs1 == 0 reads as zero without touching the register file.
    assign w_operand   = (r_state == ST_RF_READ) ? rf_rd_data : 32'd0;

    jump_target_calc u_calc (
        .pc      (w_calc_pc),
        .operand (w_operand),
        .imm     (w_calc_imm),
        .is_jalr (w_calc_jalr),
        .target  (w_target),
        .link    (w_link)
    );

`ifdef JUMP_MISALIGN_TRAP_EN
    assign w_misalign = r_target[1];
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_pc        <= 32'd0;
            r_rd        <= 5'd0;
            r_rs1       <= 5'd0;
            r_imm       <= 21'd0;
            r_jc        <= JMP_NOP;
            r_target    <= 32'd0;
            r_flush_cnt <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (jmp_valid) begin
                        r_pc  <= pc;
                        r_rd  <= rd;
                        r_rs1 <= rs1;
                        r_imm <= imm;
                        r_jc  <= jump_control;
                        if (jump_control == JMP_JAL) begin
                            r_target <= w_target;
                            r_state  <= ST_REDIRECT;
                        end else if (jump_control == JMP_JALR) begin
                            if (rs1 != 5'd0) begin
                                r_state <= ST_RF_READ;
                            end else begin
                                r_target <= w_target;
                                r_state  <= ST_REDIRECT;
                            end
                        end
                    end
                end
                ST_RF_READ: begin
                    if (rf_rd_ack) begin
                        r_target <= w_target;
                        r_state  <= ST_REDIRECT;
                    end
                end
                ST_REDIRECT: begin
                    if (w_misalign || (r_rd == 5'd0)) begin
                        r_flush_cnt <= c_flush_load;
                        r_state     <= ST_FLUSH;
                    end else begin
                        r_state <= ST_WRITEBACK;
                    end
                end
                ST_WRITEBACK: begin
                    if (wb_ready) begin
                        r_flush_cnt <= c_flush_load;
                        r_state     <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (r_flush_cnt == 3'd0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 3'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode from state only, so reset forces them at once.
    always_comb begin
        jmp_ready      = 1'b0;
        busy           = 1'b1;
        rf_rd_req      = 1'b0;
        rf_rd_addr     = 5'd0;
        wb_valid       = 1'b0;
        wb_rd          = 5'd0;
        wb_data        = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        flush          = 1'b0;
`ifdef JUMP_MISALIGN_TRAP_EN
        trap_misalign  = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                jmp_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_RF_READ: begin
                rf_rd_req  = 1'b1;
                rf_rd_addr = r_rs1;
            end
            ST_REDIRECT: begin
`ifdef JUMP_MISALIGN_TRAP_EN
                trap_misalign = w_misalign;
`endif
                redirect_valid = !w_misalign;
                redirect_pc    = w_misalign ? 32'd0 : r_target;
            end
            ST_WRITEBACK: begin
                wb_valid = 1'b1;
                wb_rd    = r_rd;
                wb_data  = w_link;
            end
            ST_FLUSH: begin
                flush = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

endmodule : jump_redirect_ctrl
`default_nettype wire

// File: tb/tb_jump_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_jump_redirect_ctrl
// Description : Self-checking bench for jump_redirect_ctrl. A table of
//               directed jump vectors with hand-computed results is applied
//               in a loop; reset behaviour and mid-operation reset are
//               hand-written sequences. JUMP_MISALIGN_TRAP_EN adds a trap
//               vector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jump_redirect_ctrl;
    import jump_redirect_ctrl_pkg::*;

    localparam int FLUSH_CYCLES = 2;

    logic        clk;
    logic        reset;
    logic        jmp_valid;
    logic        jmp_ready;
    logic [1:0]  jump_control;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [20:0] imm;
    logic [31:0] pc;
    logic        rf_rd_req;
    logic [4:0]  rf_rd_addr;
    logic        rf_rd_ack;
    logic [31:0] rf_rd_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        busy;
`ifdef JUMP_MISALIGN_TRAP_EN
    logic        trap_misalign;
`endif

    int total = 0;
    int bad   = 0;

    jump_redirect_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk            (clk),
        .reset          (reset),
        .jmp_valid      (jmp_valid),
        .jmp_ready      (jmp_ready),
        .jump_control   (jump_control),
        .rd             (rd),
        .rs1            (rs1),
        .imm            (imm),
        .pc             (pc),
        .rf_rd_req      (rf_rd_req),
        .rf_rd_addr     (rf_rd_addr),
        .rf_rd_ack      (rf_rd_ack),
        .rf_rd_data     (rf_rd_data),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .wb_ready       (wb_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .busy           (busy)
`ifdef JUMP_MISALIGN_TRAP_EN
        ,
        .trap_misalign  (trap_misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  jc;
        logic [31:0] pc;
        logic [20:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rd;
        logic [31:0] rf_data;
        int          ack_dly;
        int          wb_dly;
        bit          inject;
        int          exp_redir;
        logic [31:0] exp_pc;
        int          exp_lat;
        bit          exp_read;
        bit          exp_wb;
        logic [31:0] exp_link;
        int          exp_flush;
        int          exp_trap;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_jmp_ready"}, {31'd0, jmp_ready}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_rf_rd_req"}, {31'd0, rf_rd_req}, 32'd0);
        chk({tag, "_rf_rd_addr"}, {27'd0, rf_rd_addr}, 32'd0);
        chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd0);
        chk({tag, "_wb_data"}, wb_data, 32'd0);
        chk({tag, "_redirect_valid"}, {31'd0, redirect_valid}, 32'd0);
        chk({tag, "_redirect_pc"}, redirect_pc, 32'd0);
        chk({tag, "_flush"}, {31'd0, flush}, 32'd0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   req_n, wb_n, fl_n, rv_n, tr_n, lat, cyc;
        bit   done;
        logic [31:0] rpc;
        string t;
        t = $sformatf("v%0d", idx);
        req_n = 0; wb_n = 0; fl_n = 0; rv_n = 0; tr_n = 0; lat = 0; rpc = 32'd0;
        chk({t, "_idle_ready"}, {31'd0, jmp_ready}, 32'd1);
        jmp_valid    = 1'b1;
        jump_control = v.jc;
        pc           = v.pc;
        imm          = v.imm;
        rs1          = v.rs1;
        rd           = v.rd;
        step();
        jmp_valid = 1'b0;
        cyc  = 1;
        done = 1'b0;
        while (cyc <= 60 && !done) begin
            if (!busy) begin
                done      = 1'b1;
                jmp_valid = 1'b0;
            end else begin
                chk({t, "_busy_ready"}, {31'd0, jmp_ready}, 32'd0);
                if (rf_rd_req) begin
                    req_n++;
                    chk({t, "_rf_addr"}, {27'd0, rf_rd_addr}, {27'd0, v.rs1});
                    if (req_n == v.ack_dly + 1) begin
                        rf_rd_ack  = 1'b1;
                        rf_rd_data = v.rf_data;
                    end else begin
                        rf_rd_ack  = 1'b0;
                        rf_rd_data = 32'hDEADBEEF;
                    end
                end else begin
                    rf_rd_ack  = 1'b0;
                    rf_rd_data = 32'hDEADBEEF;
                end
                if (redirect_valid) begin
                    rv_n++;
                    rpc = redirect_pc;
                    lat = cyc;
                end
                if (wb_valid) begin
                    wb_n++;
                    chk({t, "_wb_rd"}, {27'd0, wb_rd}, {27'd0, v.rd});
                    chk({t, "_wb_data"}, wb_data, v.exp_link);
                    wb_ready = (wb_n == v.wb_dly + 1);
                end else begin
                    wb_ready = 1'b0;
                end
                if (flush) fl_n++;
`ifdef JUMP_MISALIGN_TRAP_EN
                if (trap_misalign) tr_n++;
`endif
                if (v.inject) begin
                    // A competing jump offered while busy must be ignored.
                    jmp_valid    = 1'b1;
                    jump_control = JMP_JAL;
                    pc           = 32'hAAAA0000;
                    imm          = 21'h000100;
                    rd           = 5'd9;
                    rs1          = 5'd9;
                end
                step();
                cyc++;
            end
        end
        jmp_valid  = 1'b0;
        rf_rd_ack  = 1'b0;
        wb_ready   = 1'b0;
        chk({t, "_timeout_busy"}, {31'd0, busy}, 32'd0);
        chk({t, "_redirect_count"}, rv_n, v.exp_redir);
        if (v.exp_redir != 0) begin
            chk({t, "_redirect_pc"}, rpc, v.exp_pc);
            chk({t, "_latency"}, lat, v.exp_lat);
        end
        chk({t, "_rf_req_cycles"}, req_n, v.exp_read ? v.ack_dly + 1 : 0);
        chk({t, "_wb_cycles"}, wb_n, v.exp_wb ? v.wb_dly + 1 : 0);
        chk({t, "_flush_cycles"}, fl_n, v.exp_flush);
`ifdef JUMP_MISALIGN_TRAP_EN
        chk({t, "_trap_count"}, tr_n, v.exp_trap);
`endif
        step();
    endtask

    initial begin
        int rv_n;
        reset        = 1'b1;
        jmp_valid    = 1'b0;
        jump_control = JMP_NOP;
        rd           = 5'd0;
        rs1          = 5'd0;
        imm          = 21'd0;
        pc           = 32'd0;
        rf_rd_ack    = 1'b0;
        rf_rd_data   = 32'hDEADBEEF;
        wb_ready     = 1'b0;

        //          jc        pc            imm         rs1   rd     rf_data       ack wb inj  redir exp_pc        lat rd wb  link          flush         trap
        vecs.push_back('{JMP_JAL,  32'h00000100, 21'h000010, 5'd0, 5'd1,  32'h0,        0, 0, 1'b0, 1, 32'h00000110, 1, 1'b0, 1'b1, 32'h00000104, FLUSH_CYCLES, 0});
        vecs.push_back('{JMP_JALR, 32'h00000200, 21'h000FFC, 5'd5, 5'd2,  32'h00002001, 0, 0, 1'b0, 1, 32'h00001FFC, 2, 1'b1, 1'b1, 32'h00000204, FLUSH_CYCLES, 0});
        vecs.push_back('{JMP_JAL,  32'h00000008, 21'h1FFFF0, 5'd0, 5'd0,  32'h0,        0, 0, 1'b0, 1, 32'hFFFFFFF8, 1, 1'b0, 1'b0, 32'h0,        FLUSH_CYCLES, 0});
        vecs.push_back('{JMP_JALR, 32'h00003000, 21'h000008, 5'd3, 5'd4,  32'h00001000, 3, 2, 1'b1, 1, 32'h00001008, 5, 1'b1, 1'b1, 32'h00003004, FLUSH_CYCLES, 0});
        vecs.push_back('{JMP_JALR, 32'h00000040, 21'h0007F9, 5'd0, 5'd1,  32'h0,        0, 0, 1'b0, 1, 32'h000007F8, 1, 1'b0, 1'b1, 32'h00000044, FLUSH_CYCLES, 0});
        vecs.push_back('{JMP_NOP,  32'h00000060, 21'h000010, 5'd0, 5'd1,  32'h0,        0, 0, 1'b0, 0, 32'h0,        0, 1'b0, 1'b0, 32'h0,        0,            0});
        vecs.push_back('{2'b11,    32'h00000060, 21'h000010, 5'd2, 5'd1,  32'h0,        0, 0, 1'b0, 0, 32'h0,        0, 1'b0, 1'b0, 32'h0,        0,            0});
        vecs.push_back('{JMP_JAL,  32'hFFFFFFFC, 21'h000008, 5'd0, 5'd31, 32'h0,        0, 1, 1'b0, 1, 32'h00000004, 1, 1'b0, 1'b1, 32'h00000000, FLUSH_CYCLES, 0});
        vecs.push_back('{JMP_JALR, 32'h00000700, 21'h000FF0, 5'd1, 5'd0,  32'h00000000, 1, 0, 1'b0, 1, 32'hFFFFFFF0, 3, 1'b1, 1'b0, 32'h0,        FLUSH_CYCLES, 0});
`ifdef JUMP_MISALIGN_TRAP_EN
        vecs.push_back('{JMP_JAL,  32'h00000100, 21'h000002, 5'd0, 5'd1,  32'h0,        0, 0, 1'b0, 0, 32'h0,        0, 1'b0, 1'b0, 32'h0,        FLUSH_CYCLES, 1});
`endif

        // Outputs while reset is held.
        step();
        step();
        check_idle_outputs("in_reset");
        @(negedge clk);
        reset = 1'b0;
        step();
        check_idle_outputs("after_reset");

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Reset asserted while waiting in RF_READ.
        jmp_valid    = 1'b1;
        jump_control = JMP_JALR;
        pc           = 32'h00000500;
        rs1          = 5'd7;
        rd           = 5'd3;
        imm          = 21'h000010;
        step();
        jmp_valid = 1'b0;
        step();
        chk("mid_rst_pre_req", {31'd0, rf_rd_req}, 32'd1);
        chk("mid_rst_pre_addr", {27'd0, rf_rd_addr}, 32'd7);
        #2;
        reset = 1'b1;
        #1;
        check_idle_outputs("mid_rst");
        @(negedge clk);
        reset      = 1'b0;
        rf_rd_ack  = 1'b1;
        rf_rd_data = 32'h00004000;
        rv_n = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (redirect_valid || wb_valid || rf_rd_req) rv_n++;
        end
        rf_rd_ack = 1'b0;
        chk("post_rst_activity", rv_n, 0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_jump_redirect_ctrl
`default_nettype wire
